ps2_key_tracker: RTL and testbench

Consumes raw PS/2 scan-code bytes from the keyboard receiver FIFO and turns them into a key-level state for the display path. Decodes set-2 make/break/extended sequences and tracks shift and caps-lock state. Outputs the code of the key currently held, its lowercase ASCII value, a display-enable flag and a press counter. Sits between the PS/2 receiver and the ASCII/hex seven-segment decoders.

---
 rtl/ps2_key_tracker_if.sv | 9 +
 rtl/ps2_key_tracker.sv | 146 ++++++++++++++
 tb/tb_ps2_key_tracker.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/ps2_key_tracker_if.sv
// Byte-wide pop handshake between the PS/2 receiver FIFO (master) and its consumer (slave).
interface ps2_key_tracker_if;
  logic [7:0] data_in;
  logic       ready;
  logic       nextdata_n;

  modport master (output data_in, ready, input nextdata_n);
  modport slave  (input data_in, ready, output nextdata_n);
endinterface

// File: rtl/ps2_key_tracker.sv
// Set-2 scan-code decoder: make/break/extended prefixes, shift/caps tracking, held-key state.
//   state | meaning
//   IDLE  | waiting for a byte; consumes data_in at the edge ready is seen
//   POP   | nextdata_n low for one cycle so the FIFO advances
module ps2_key_tracker (
  input  logic                      clk,
  input  logic                      reset,
  ps2_key_tracker_if.slave          fifo,
  output logic [7:0]                key_code,
  output logic [7:0]                ascii,
  output logic                      key_valid,
  output logic                      shift,
  output logic                      is_caps,
  output logic [7:0]                press_count
);

  typedef enum logic {ST_IDLE = 1'b0, ST_POP = 1'b1} state_e;

  state_e     state_q, state_d;
  logic       take;
  logic       brk_pend_q, brk_pend_d;
  logic       ext_pend_q, ext_pend_d;
  logic       shl_q, shl_d;
  logic       shr_q, shr_d;
  logic       caps_held_q, caps_held_d;
  logic       caps_q, caps_d;
  logic       key_valid_q, key_valid_d;
  logic [7:0] key_code_q, key_code_d;
  logic [7:0] press_count_q, press_count_d;

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (fifo.ready) state_d = ST_POP;
      ST_POP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    fifo.nextdata_n = (state_q != ST_POP);
    take            = (state_q == ST_IDLE) && fifo.ready;
  end

  always_comb begin
    brk_pend_d    = brk_pend_q;
    ext_pend_d    = ext_pend_q;
    shl_d         = shl_q;
    shr_d         = shr_q;
    caps_held_d   = caps_held_q;
    caps_d        = caps_q;
    key_valid_d   = key_valid_q;
    key_code_d    = key_code_q;
    press_count_d = press_count_q;
    if (take) begin
      case (fifo.data_in)
        8'hF0: brk_pend_d = 1'b1;
        8'hE0: ext_pend_d = 1'b1;
        default: begin
          brk_pend_d = 1'b0;
          ext_pend_d = 1'b0;
          // Extended codes (including the E0 12 fake shift) never touch key state.
          if (!ext_pend_q) begin
            case (fifo.data_in)
              8'h12: shl_d = !brk_pend_q;
              8'h59: shr_d = !brk_pend_q;
              8'h58: begin
                if (brk_pend_q) begin
                  caps_held_d = 1'b0;
                end else if (!caps_held_q) begin
                  caps_d      = !caps_q;
                  caps_held_d = 1'b1;
                end
              end
              default: begin
                if (brk_pend_q) begin
                  if (fifo.data_in == key_code_q) key_valid_d = 1'b0;
                end else if (!(key_valid_q && fifo.data_in == key_code_q)) begin
                  key_code_d    = fifo.data_in;
                  key_valid_d   = 1'b1;
                  press_count_d = press_count_q + 8'd1;
                end
              end
            endcase
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      brk_pend_q    <= 1'b0;
      ext_pend_q    <= 1'b0;
      shl_q         <= 1'b0;
      shr_q         <= 1'b0;
      caps_held_q   <= 1'b0;
      caps_q        <= 1'b0;
      key_valid_q   <= 1'b0;
      key_code_q    <= 8'h00;
      press_count_q <= 8'h00;
    end else begin
      brk_pend_q    <= brk_pend_d;
      ext_pend_q    <= ext_pend_d;
      shl_q         <= shl_d;
      shr_q         <= shr_d;
      caps_held_q   <= caps_held_d;
      caps_q        <= caps_d;
      key_valid_q   <= key_valid_d;
      key_code_q    <= key_code_d;
      press_count_q <= press_count_d;
    end
  end

  always_comb begin
    case (key_code_q)
      8'h1C: ascii = 8'h61;  8'h32: ascii = 8'h62;  8'h21: ascii = 8'h63;
      8'h23: ascii = 8'h64;  8'h24: ascii = 8'h65;  8'h2B: ascii = 8'h66;
      8'h34: ascii = 8'h67;  8'h33: ascii = 8'h68;  8'h43: ascii = 8'h69;
      8'h3B: ascii = 8'h6A;  8'h42: ascii = 8'h6B;  8'h4B: ascii = 8'h6C;
      8'h3A: ascii = 8'h6D;  8'h31: ascii = 8'h6E;  8'h44: ascii = 8'h6F;
      8'h4D: ascii = 8'h70;  8'h15: ascii = 8'h71;  8'h2D: ascii = 8'h72;
      8'h1B: ascii = 8'h73;  8'h2C: ascii = 8'h74;  8'h3C: ascii = 8'h75;
      8'h2A: ascii = 8'h76;  8'h1D: ascii = 8'h77;  8'h22: ascii = 8'h78;
      8'h35: ascii = 8'h79;  8'h1A: ascii = 8'h7A;
      8'h45: ascii = 8'h30;  8'h16: ascii = 8'h31;  8'h1E: ascii = 8'h32;
      8'h26: ascii = 8'h33;  8'h25: ascii = 8'h34;  8'h2E: ascii = 8'h35;
      8'h36: ascii = 8'h36;  8'h3D: ascii = 8'h37;  8'h3E: ascii = 8'h38;
      8'h46: ascii = 8'h39;
      8'h29: ascii = 8'h20;
      default: ascii = 8'h00;
    endcase
  end

  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;
  assign shift       = shl_q | shr_q;
  assign is_caps     = caps_q;
  assign press_count = press_count_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed vector bench for ps2_key_tracker: byte table with hand-derived outputs plus reset/wrap sequences.
module tb_ps2_key_tracker;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] key_code, ascii, press_count;
  logic       key_valid, shift, is_caps;

  ps2_key_tracker_if fifo_if ();

  ps2_key_tracker dut (
    .clk        (clk),
    .reset      (reset),
    .fifo       (fifo_if.slave),
    .key_code   (key_code),
    .ascii      (ascii),
    .key_valid  (key_valid),
    .shift      (shift),
    .is_caps    (is_caps),
    .press_count(press_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    logic [7:0] kc;
    logic [7:0] asc;
    logic       kv;
    logic       sh;
    logic       caps;
    logic [7:0] pc;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   failed = 0;
  int   pulses = 0;
  int   bytes_sent = 0;

  always @(negedge clk) if (!reset && !fifo_if.nextdata_n) pulses++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] b, input logic [7:0] kc, input logic [7:0] asc,
                     input logic kv, input logic sh, input logic caps, input logic [7:0] pc);
    vec_t v;
    v.b = b; v.kc = kc; v.asc = asc; v.kv = kv; v.sh = sh; v.caps = caps; v.pc = pc;
    vecs.push_back(v);
  endtask

  // Presents one byte, waits for the pop pulse and checks it lasts exactly one cycle.
  task automatic send(input logic [7:0] b);
    bit got = 0;
    fifo_if.data_in = b;
    fifo_if.ready   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (!fifo_if.nextdata_n) begin got = 1; break; end
    end
    fifo_if.ready   = 1'b0;
    fifo_if.data_in = 8'($urandom);
    bytes_sent++;
    if (!got) begin
      tests++; failed++;
      $display("FAIL pop_timeout: byte %0h got no pop, required one", b);
    end else begin
      @(posedge clk); #1;
      chk($sformatf("pulse_width_%0h", b), {31'd0, fifo_if.nextdata_n}, 32'd1);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] code;
    fifo_if.data_in = 8'h00;
    fifo_if.ready   = 1'b0;

    //   byte    kc     ascii  kv sh cp pc
    add(8'h1C, 8'h1C, 8'h61, 1, 0, 0, 8'd1);
    add(8'hF0, 8'h1C, 8'h61, 1, 0, 0, 8'd1);
    add(8'h1C, 8'h1C, 8'h61, 0, 0, 0, 8'd1);
    add(8'h1C, 8'h1C, 8'h61, 1, 0, 0, 8'd2);
    add(8'h1C, 8'h1C, 8'h61, 1, 0, 0, 8'd2);
    add(8'h1C, 8'h1C, 8'h61, 1, 0, 0, 8'd2);
    add(8'hF0, 8'h1C, 8'h61, 1, 0, 0, 8'd2);
    add(8'h1C, 8'h1C, 8'h61, 0, 0, 0, 8'd2);
    add(8'h12, 8'h1C, 8'h61, 0, 1, 0, 8'd2);
    add(8'h58, 8'h1C, 8'h61, 0, 1, 1, 8'd2);
    add(8'h58, 8'h1C, 8'h61, 0, 1, 1, 8'd2);
    add(8'hF0, 8'h1C, 8'h61, 0, 1, 1, 8'd2);
    add(8'h58, 8'h1C, 8'h61, 0, 1, 1, 8'd2);
    add(8'h59, 8'h1C, 8'h61, 0, 1, 1, 8'd2);
    add(8'hF0, 8'h1C, 8'h61, 0, 1, 1, 8'd2);
    add(8'h12, 8'h1C, 8'h61, 0, 1, 1, 8'd2);
    add(8'hF0, 8'h1C, 8'h61, 0, 1, 1, 8'd2);
    add(8'h59, 8'h1C, 8'h61, 0, 0, 1, 8'd2);
    add(8'h58, 8'h1C, 8'h61, 0, 0, 0, 8'd2);
    add(8'hF0, 8'h1C, 8'h61, 0, 0, 0, 8'd2);
    add(8'h58, 8'h1C, 8'h61, 0, 0, 0, 8'd2);
    add(8'hE0, 8'h1C, 8'h61, 0, 0, 0, 8'd2);
    add(8'h12, 8'h1C, 8'h61, 0, 0, 0, 8'd2);
    add(8'hE0, 8'h1C, 8'h61, 0, 0, 0, 8'd2);
    add(8'h75, 8'h1C, 8'h61, 0, 0, 0, 8'd2);
    add(8'hE0, 8'h1C, 8'h61, 0, 0, 0, 8'd2);
    add(8'hF0, 8'h1C, 8'h61, 0, 0, 0, 8'd2);
    add(8'h75, 8'h1C, 8'h61, 0, 0, 0, 8'd2);
    add(8'h16, 8'h16, 8'h31, 1, 0, 0, 8'd3);
    add(8'h1E, 8'h1E, 8'h32, 1, 0, 0, 8'd4);
    add(8'hF0, 8'h1E, 8'h32, 1, 0, 0, 8'd4);
    add(8'h16, 8'h1E, 8'h32, 1, 0, 0, 8'd4);
    add(8'hF0, 8'h1E, 8'h32, 1, 0, 0, 8'd4);
    add(8'h1E, 8'h1E, 8'h32, 0, 0, 0, 8'd4);
    add(8'h29, 8'h29, 8'h20, 1, 0, 0, 8'd5);
    add(8'hF0, 8'h29, 8'h20, 1, 0, 0, 8'd5);
    add(8'h29, 8'h29, 8'h20, 0, 0, 0, 8'd5);
    add(8'hE0, 8'h29, 8'h20, 0, 0, 0, 8'd5);
    add(8'h29, 8'h29, 8'h20, 0, 0, 0, 8'd5);
    add(8'h0E, 8'h0E, 8'h00, 1, 0, 0, 8'd6);
    add(8'h45, 8'h45, 8'h30, 1, 0, 0, 8'd7);
    add(8'h1A, 8'h1A, 8'h7A, 1, 0, 0, 8'd8);

    do_reset();
    chk("rst_nextdata_n", {31'd0, fifo_if.nextdata_n}, 32'd1);
    chk("rst_key_code",   {24'd0, key_code}, 32'h00);
    chk("rst_ascii",      {24'd0, ascii}, 32'h00);
    chk("rst_key_valid",  {31'd0, key_valid}, 32'd0);
    chk("rst_shift",      {31'd0, shift}, 32'd0);
    chk("rst_is_caps",    {31'd0, is_caps}, 32'd0);
    chk("rst_press_count",{24'd0, press_count}, 32'h00);

    // Idle FIFO: nothing is popped and nothing moves.
    repeat (3) @(posedge clk);
    #1;
    chk("idle_no_pop", {31'd0, fifo_if.nextdata_n}, 32'd1);

    foreach (vecs[i]) begin
      send(vecs[i].b);
      chk($sformatf("v%0d_key_code", i),   {24'd0, key_code},    {24'd0, vecs[i].kc});
      chk($sformatf("v%0d_ascii", i),      {24'd0, ascii},       {24'd0, vecs[i].asc});
      chk($sformatf("v%0d_key_valid", i),  {31'd0, key_valid},   {31'd0, vecs[i].kv});
      chk($sformatf("v%0d_shift", i),      {31'd0, shift},       {31'd0, vecs[i].sh});
      chk($sformatf("v%0d_is_caps", i),    {31'd0, is_caps},     {31'd0, vecs[i].caps});
      chk($sformatf("v%0d_press_count", i),{24'd0, press_count}, {24'd0, vecs[i].pc});
    end
    chk("pulse_count", pulses, bytes_sent);

    // 256 distinct presses wrap the counter.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      code = (i % 2 == 1) ? 8'h32 : 8'h1C;
      send(code);
      if (i == 254) chk("wrap_ff", {24'd0, press_count}, 32'hFF);
    end
    chk("wrap_00", {24'd0, press_count}, 32'h00);
    chk("wrap_key_code", {24'd0, key_code}, 32'h32);

    // Reset between F0 and its code byte drops the pending break.
    do_reset();
    send(8'hF0);
    do_reset();
    send(8'h24);
    chk("rstbrk_key_valid", {31'd0, key_valid}, 32'd1);
    chk("rstbrk_ascii",     {24'd0, ascii}, 32'h65);
    chk("rstbrk_press",     {24'd0, press_count}, 32'd1);
    chk("rstbrk_key_code",  {24'd0, key_code}, 32'h24);

    // Reset asserted while the pop strobe is low.
    do_reset();
    fifo_if.data_in = 8'h1C;
    fifo_if.ready   = 1'b1;
    @(posedge clk); #1;
    chk("poprst_low", {31'd0, fifo_if.nextdata_n}, 32'd0);
    reset = 1'b1;
    fifo_if.ready = 1'b0;
    @(posedge clk); #1;
    chk("poprst_high", {31'd0, fifo_if.nextdata_n}, 32'd1);
    chk("poprst_key_code", {24'd0, key_code}, 32'h00);
    chk("poprst_press", {24'd0, press_count}, 32'h00);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("poprst_idle", {31'd0, fifo_if.nextdata_n}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
